// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Definitions shared by the keypad calculator datapath:
//   - keycode constants for the function keys (clear, backspace, enter)
//   - entry FSM state encoding
//   - is_digit() helper that classifies a 4-bit keycode as a decimal digit
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] KEY_BACKSPACE = 4'hB;
    localparam logic [3:0] KEY_ENTER     = 4'hE;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } entry_state_t;

    // True for keycodes 0..9 (plain decimal digit keys)
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_entry_reg_if.sv
// -----------------------------------------------------------------------------
// bcd_entry_reg_if
// Keypad-side and display-side signals of the BCD entry register.
//   master : keypad chain (drives digit/keystrobe, observes the entry)
//   slave  : the entry register itself
// Signals:
//   digit       keypad code, valid when keystrobe=1
//   keystrobe   one-cycle key event strobe
//   bcd         live entry, digit i at [4i+3:4i], digit 0 = units
//   blank       1 = display digit i dark
//   count       number of significant digits entered
//   full        count == NUM_DIGITS
//   overflow    sticky: a digit was rejected because the buffer was full
//   value       last committed entry
//   value_valid one-cycle pulse when value is updated
// -----------------------------------------------------------------------------
interface bcd_entry_reg_if #(
    parameter int NUM_DIGITS = 3
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [3:0]              digit;
    logic                    keystrobe;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   blank;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    overflow;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    value_valid;

    modport master (
        output digit, keystrobe,
        input  bcd, blank, count, full, overflow, value, value_valid
    );

    modport slave (
        input  digit, keystrobe,
        output bcd, blank, count, full, overflow, value, value_valid
    );

endinterface

// File: rtl/bcd_entry_reg_blank_mask.sv
// -----------------------------------------------------------------------------
// bcd_blank_mask
// Converts a significant-digit count into a per-digit blanking mask for the
// 7-segment decoders. Digit 0 is never blanked so an empty entry shows "0".
// Ports:
//   count_i  number of significant digits
//   blank_o  bit i = 1 -> digit i dark
// -----------------------------------------------------------------------------
module bcd_blank_mask #(
    parameter int NUM_DIGITS    = 3,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic [$clog2(NUM_DIGITS+1)-1:0] count_i,
    output logic [NUM_DIGITS-1:0]           blank_o
);

    // Blank every unused leading position except the units digit
    always_comb begin
        blank_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_o[i] = BLANK_LEADING && (32'(i) >= 32'(count_i)) && (i != 0);
        end
    end

endmodule

// File: rtl/bcd_entry_reg.sv
// -----------------------------------------------------------------------------
// bcd_entry_reg
// N-digit BCD keypad entry register. Digit keys shift into the units position,
// backspace removes the most recently entered digit, clear empties the buffer,
// enter commits the entry to value with a one-cycle value_valid pulse.
// Leading zeros are not counted; digits beyond capacity set a sticky overflow.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   bus    bcd_entry_reg_if.slave (key input + entry/display outputs)
// -----------------------------------------------------------------------------
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter int         NUM_DIGITS     = 3,
    parameter logic [3:0] CLEAR_CODE     = KEY_CLEAR,
    parameter logic [3:0] BACKSPACE_CODE = KEY_BACKSPACE,
    parameter logic [3:0] ENTER_CODE     = KEY_ENTER,
    parameter bit         BLANK_LEADING  = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    bcd_entry_reg_if.slave bus
);

    localparam int            W      = 4 * NUM_DIGITS;
    localparam int            CW     = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);

    // Function keys must not shadow a digit key; digit count must be sane
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("bcd_entry_reg: NUM_DIGITS must be 1..8");
    end
    if (is_digit(CLEAR_CODE) || is_digit(BACKSPACE_CODE) || is_digit(ENTER_CODE)) begin : g_bad_codes
        $error("bcd_entry_reg: function keycodes must be outside 0..9");
    end

    entry_state_t  state_q,    state_d;
    logic [W-1:0]  bcd_q,      bcd_d;
    logic [CW-1:0] count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  value_q,    value_d;
    logic          valid_q,    valid_d;
    logic [NUM_DIGITS-1:0] blank_s;

    // Key decode, shift/count update and FSM next state
    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        if (bus.keystrobe) begin
            if (bus.digit == CLEAR_CODE) begin
                state_d    = EMPTY;
                bcd_d      = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end else if (bus.digit == ENTER_CODE) begin
                value_d    = bcd_q;
                valid_d    = 1'b1;
                state_d    = EMPTY;
                bcd_d      = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end else if (bus.digit == BACKSPACE_CODE) begin
                overflow_d = 1'b0;
                if (state_q != EMPTY) begin
                    bcd_d   = bcd_q >> 3'd4;
                    count_d = count_q - CW'(1);
                    // Falling back to zero digits returns to EMPTY (also covers N=1)
                    state_d = (count_q == CW'(1)) ? EMPTY : ENTRY;
                end else begin
                    state_d = EMPTY;
                end
            end else if (is_digit(bus.digit)) begin
                case (state_q)
                    EMPTY: begin
                        // A leading zero is swallowed without being counted
                        if (bus.digit != 4'd0) begin
                            bcd_d   = W'(bus.digit);
                            count_d = CW'(1);
                            state_d = (NUM_DIGITS == 1) ? FULL : ENTRY;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                    ENTRY: begin
                        bcd_d   = (bcd_q << 3'd4) | W'(bus.digit);
                        count_d = count_q + CW'(1);
                        state_d = (count_q + CW'(1) == CNT_MAX) ? FULL : ENTRY;
                    end
                    FULL: begin
                        overflow_d = 1'b1;
                    end
                    default: begin
                        state_d    = EMPTY;
                        bcd_d      = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end
                endcase
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= EMPTY;
            bcd_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
        end
    end

    bcd_blank_mask #(
        .NUM_DIGITS    (NUM_DIGITS),
        .BLANK_LEADING (BLANK_LEADING)
    ) u_blank (
        .count_i (count_q),
        .blank_o (blank_s)
    );

    assign bus.bcd         = bcd_q;
    assign bus.count       = count_q;
    assign bus.full        = (count_q == CNT_MAX);
    assign bus.blank       = blank_s;
    assign bus.overflow    = overflow_q;
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;

endmodule

// File: tb/tb_bcd_entry_reg.sv
// -----------------------------------------------------------------------------
// tb_bcd_entry_reg
// Drives the same key stream into three entry registers (1, 3 and 6 digits)
// and compares every output after each clock against a list-of-digits model.
// -----------------------------------------------------------------------------
module tb_bcd_entry_reg;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    bcd_entry_reg_if #(.NUM_DIGITS(1)) if1 ();
    bcd_entry_reg_if #(.NUM_DIGITS(3)) if3 ();
    bcd_entry_reg_if #(.NUM_DIGITS(6)) if6 ();

    bcd_entry_reg #(.NUM_DIGITS(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));
    bcd_entry_reg #(.NUM_DIGITS(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));
    bcd_entry_reg #(.NUM_DIGITS(6)) dut6 (.clock(clock), .reset(reset), .bus(if6));

    // Observed outputs, normalised to common widths
    logic [31:0] o_bcd [3];
    logic [31:0] o_val [3];
    logic [7:0]  o_blank [3];
    logic [3:0]  o_cnt [3];
    logic        o_full [3];
    logic        o_ovf [3];
    logic        o_vv [3];

    assign o_bcd[0] = 32'(if1.bcd);   assign o_bcd[1] = 32'(if3.bcd);   assign o_bcd[2] = 32'(if6.bcd);
    assign o_val[0] = 32'(if1.value); assign o_val[1] = 32'(if3.value); assign o_val[2] = 32'(if6.value);
    assign o_blank[0] = 8'(if1.blank); assign o_blank[1] = 8'(if3.blank); assign o_blank[2] = 8'(if6.blank);
    assign o_cnt[0] = 4'(if1.count);  assign o_cnt[1] = 4'(if3.count);  assign o_cnt[2] = 4'(if6.count);
    assign o_full[0] = if1.full;      assign o_full[1] = if3.full;      assign o_full[2] = if6.full;
    assign o_ovf[0] = if1.overflow;   assign o_ovf[1] = if3.overflow;   assign o_ovf[2] = if6.overflow;
    assign o_vv[0] = if1.value_valid; assign o_vv[1] = if3.value_valid; assign o_vv[2] = if6.value_valid;

    // Reference model: entered digits in typing order (oldest first)
    int          nd [3] = '{1, 3, 6};
    int          dig [3][8];
    int          cnt [3];
    bit          ovf [3];
    int unsigned val [3];
    bit          vv [3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned model_bcd(input int k);
        int unsigned v = 0;
        for (int j = 0; j < cnt[k]; j++) v = v * 16 + dig[k][j];
        return v;
    endfunction

    task automatic model_step(input int k, input bit rst, input bit stb, input int code);
        vv[k] = 1'b0;
        if (rst) begin
            cnt[k] = 0; ovf[k] = 1'b0; val[k] = 0;
        end else if (stb) begin
            if (code == 12) begin
                cnt[k] = 0; ovf[k] = 1'b0;
            end else if (code == 14) begin
                val[k] = model_bcd(k); vv[k] = 1'b1; cnt[k] = 0; ovf[k] = 1'b0;
            end else if (code == 11) begin
                if (cnt[k] > 0) cnt[k]--;
                ovf[k] = 1'b0;
            end else if (code <= 9) begin
                if (cnt[k] == 0 && code == 0) begin
                    // leading zero ignored
                end else if (cnt[k] == nd[k]) begin
                    ovf[k] = 1'b1;
                end else begin
                    dig[k][cnt[k]] = code;
                    cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all(input int k);
        logic [7:0] eb;
        string p;
        eb = 8'h00;
        for (int i = 1; i < nd[k]; i++) if (i >= cnt[k]) eb[i] = 1'b1;
        p = $sformatf("n%0d_", nd[k]);
        check({p, "bcd"},   o_bcd[k],           model_bcd(k));
        check({p, "count"}, 32'(o_cnt[k]),      32'(cnt[k]));
        check({p, "full"},  32'(o_full[k]),     32'(cnt[k] == nd[k]));
        check({p, "blank"}, 32'(o_blank[k]),    32'(eb));
        check({p, "ovf"},   32'(o_ovf[k]),      32'(ovf[k]));
        check({p, "value"}, o_val[k],           val[k]);
        check({p, "vvalid"}, 32'(o_vv[k]),      32'(vv[k]));
    endtask

    task automatic step(input bit rst, input bit stb, input int code);
        @(negedge clock);
        reset = rst;
        if1.keystrobe = stb; if3.keystrobe = stb; if6.keystrobe = stb;
        if1.digit = 4'(code); if3.digit = 4'(code); if6.digit = 4'(code);
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            model_step(k, rst, stb, code);
            check_all(k);
        end
    endtask

    task automatic key(input int code);
        step(1'b0, 1'b1, code);
    endtask

    int seq_a [] = '{1, 2, 3, 4, 11, 12, 0, 0, 5, 12, 4, 2, 14};
    int seq_b [] = '{9, 8, 7, 6, 5, 4, 3, 11, 10, 13, 15, 14};

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        if1.keystrobe = 1'b0; if3.keystrobe = 1'b0; if6.keystrobe = 1'b0;
        if1.digit = 4'd0; if3.digit = 4'd0; if6.digit = 4'd0;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; ovf[k] = 1'b0; val[k] = 0; vv[k] = 1'b0;
        end

        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        foreach (seq_a[i]) key(seq_a[i]);
        step(1'b0, 1'b0, 0);          // valid pulse must drop after one cycle
        key(14);                      // commit of an empty entry
        key(7); key(8);
        step(1'b1, 1'b1, 9);          // reset wins over a simultaneous strobe
        key(10); key(13); key(15);
        foreach (seq_b[i]) key(seq_b[i]);

        for (int n = 0; n < 600; n++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            end else if (r < 20) begin
                step(1'b0, 1'b0, int'($urandom_range(0, 15)));
            end else begin
                c = (r < 70) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
                key(c);
            end
        end
        step(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
